// File: rtl/serial_audio_pkg.sv
// Shared definitions for the serial audio feeder/encoder path.
// Default sample width and sequencer state encoding.
package serial_audio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LEFT  = ST_LEFT,
        RIGHT = ST_RIGHT
    } seq_state_e;

endpackage

// File: rtl/serial_audio_frame_fifo.sv
// Stereo frame FIFO: depth x {left,right}, combinational head and next-head read.
// Occupancy is tracked by a level counter rather than pointer compare.
module serial_audio_frame_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [2*DW-1:0] din_i,
    output logic [2*DW-1:0] head_o,
    output logic [2*DW-1:0] next_o,
    output logic [LW-1:0] level_o,
    output logic [LW-1:0] level_d_o
);

    logic [2*DW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]   rd_nxt;
    logic [LW-1:0]   level_q, level_d;

    assign rd_nxt = rd_ptr_q + AW'(1);
    assign head_o = mem_q[rd_ptr_q];
    assign next_o = mem_q[rd_nxt];

    always_comb begin
        level_d = level_q;
        unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_nxt;
        end
    end

    // Storage carries no reset; validity is governed entirely by level_q.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/serial_audio_frame_feeder.sv
// Stereo frame buffer and L/R sequencer feeding serial_audio_encoder.
// Each buffered frame is replayed as a left word then a right word.
module serial_audio_frame_feeder
    import serial_audio_pkg::*;
#(
    parameter int data_width = DATA_W,
    parameter int depth      = 4,
    localparam int LW        = $clog2(depth) + 1
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [data_width-1:0] i_left,
    input  logic [data_width-1:0] i_right,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_is_left,
    output logic [data_width-1:0] o_data,
    output logic [LW-1:0]         o_level
);

    localparam int DW = data_width;

    seq_state_e      state_q, state_d;
    logic            valid_q, valid_d;
    logic            left_q, left_d;
    logic [DW-1:0]   data_q, data_d;
    logic            ready_q;
    logic            push, pop;
    logic [2*DW-1:0] head, next;
    logic [LW-1:0]   level, level_d;

    assign push = i_valid & ready_q;
    assign pop  = (state_q == RIGHT) & o_ready;

    serial_audio_frame_fifo #(
        .DW    (DW),
        .DEPTH (depth)
    ) u_fifo (
        .clk       (sclk),
        .reset     (reset),
        .push_i    (push),
        .pop_i     (pop),
        .din_i     ({i_left, i_right}),
        .head_o    (head),
        .next_o    (next),
        .level_o   (level),
        .level_d_o (level_d)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        left_d  = left_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (level != '0) begin
                    data_d  = head[2*DW-1:DW];
                    left_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = LEFT;
                end
            end
            LEFT: begin
                if (o_ready) begin
                    data_d  = head[DW-1:0];
                    left_d  = 1'b0;
                    state_d = RIGHT;
                end
            end
            RIGHT: begin
                if (o_ready) begin
                    // The head still counts in level, so a follower needs level > 1.
                    if (level > LW'(1)) begin
                        data_d  = next[2*DW-1:DW];
                        left_d  = 1'b1;
                        state_d = LEFT;
                    end else begin
                        valid_d = 1'b0;
                        left_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                left_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            left_q  <= 1'b1;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            left_q  <= left_d;
            data_q  <= data_d;
            ready_q <= (level_d != LW'(depth));
        end
    end

    assign i_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_is_left = left_q;
    assign o_data    = data_q;
    assign o_level   = level;

endmodule

// File: tb/tb_serial_audio_frame_feeder.sv
// Scoreboard bench for serial_audio_frame_feeder.
module tb_serial_audio_frame_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          sclk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [DW-1:0] i_left = '0;
    logic [DW-1:0] i_right = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic          o_is_left;
    logic [DW-1:0] o_data;
    logic [LW-1:0] o_level;

    int total = 0;
    int bad   = 0;

    logic [DW:0] sb_q [$];
    int          lvl_m = 0;
    logic        rdy_m = 1'b0;
    logic        armed = 1'b0;
    logic        hold_prev = 1'b0;
    logic [DW:0] prev_w = '0;

    serial_audio_frame_feeder #(
        .data_width (DW),
        .depth      (DEPTH)
    ) dut (
        .sclk      (sclk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_left    (i_left),
        .i_right   (i_right),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_is_left (o_is_left),
        .o_data    (o_data),
        .o_level   (o_level)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: compare on the falling edge, predict the next rising edge.
    always @(negedge sclk) begin
        logic       psh, pp;
        logic [DW:0] e;
        if (armed) begin
            chk("level", 64'(o_level), 64'(lvl_m));
            chk("i_ready", 64'(i_ready), 64'(rdy_m));
            if (hold_prev)
                chk("hold", 64'({o_is_left, o_data}), 64'(prev_w));
            if (reset) begin
                sb_q.delete();
                lvl_m = 0;
                rdy_m = 1'b0;
                hold_prev = 1'b0;
            end else begin
                psh = i_valid & i_ready;
                pp  = o_valid & o_ready & ~o_is_left;
                if (o_valid && o_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 64'(1), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("word", 64'({o_is_left, o_data}), 64'(e));
                    end
                end
                if (psh) begin
                    sb_q.push_back({1'b1, i_left});
                    sb_q.push_back({1'b0, i_right});
                end
                lvl_m = lvl_m + int'(psh) - int'(pp);
                rdy_m = (lvl_m != DEPTH);
                hold_prev = o_valid & ~o_ready;
                prev_w = {o_is_left, o_data};
            end
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit ok = 0;
        i_valid = 1'b1;
        i_left  = l;
        i_right = r;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge sclk);
            if (i_ready) ok = 1;
            step();
        end
        i_valid = 1'b0;
        if (!ok) chk("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (o_valid) ok = 1;
            else step();
        end
        if (!ok) chk("valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        bit ok = 0;
        o_ready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (sb_q.size() == 0 && !o_valid) ok = 1;
            else step();
        end
        if (!ok) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        step();
        armed = 1'b1;
        step();
        @(negedge sclk);
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_left", 64'(o_is_left), 64'(1));
        chk("rst_data", 64'(o_data), 64'(0));
        chk("rst_level", 64'(o_level), 64'(0));
        @(posedge sclk);
        #1;
        reset = 1'b0;
        step();
        chk("rdy_after_rst", 64'(i_ready), 64'(1));

        // 1: single frame, latency and L/R order
        o_ready = 1'b1;
        push_frame(32'hAAA7AAA3, 32'hAAA80AA4);
        chk("lat_n", 64'(o_valid), 64'(0));
        step();
        chk("lat_n1", 64'(o_valid), 64'(1));
        chk("lat_word", 64'({o_is_left, o_data}), 64'({1'b1, 32'hAAA7AAA3}));
        drain();

        // 2: fill to depth, fifth frame held until one pop
        o_ready = 1'b0;
        for (int f = 0; f < DEPTH; f++)
            push_frame(32'h1000 + 32'(f), 32'h2000 + 32'(f));
        chk("full_rdy", 64'(i_ready), 64'(0));
        chk("full_lvl", 64'(o_level), 64'(DEPTH));
        i_valid = 1'b1;
        i_left  = 32'h1004;
        i_right = 32'h2004;
        repeat (3) step();
        chk("full_hold", 64'(i_ready), 64'(0));
        chk("full_lvl2", 64'(o_level), 64'(DEPTH));
        o_ready = 1'b1;
        push_frame(32'h1004, 32'h2004);
        drain();

        // 3: stalls mid-frame
        o_ready = 1'b0;
        push_frame(32'h3000, 32'h3001);
        push_frame(32'h3002, 32'h3003);
        wait_valid();
        for (int c = 0; c < 12; c++) begin
            o_ready = (c % 3 == 0);
            step();
        end
        drain();

        // 4: steady stream, push aligned with each pop
        o_ready = 1'b0;
        push_frame(32'h4000, 32'h5000);
        push_frame(32'h4001, 32'h5001);
        wait_valid();
        o_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            i_valid = o_valid & ~o_is_left;
            i_left  = 32'h4100 + 32'(c);
            i_right = 32'h5100 + 32'(c);
            step();
            chk("stream_valid", 64'(o_valid), 64'(1));
            chk("stream_lvl", 64'(o_level), 64'(2));
        end
        i_valid = 1'b0;
        drain();

        // 5: reset while in RIGHT with two frames stored
        o_ready = 1'b0;
        push_frame(32'h6000, 32'h6001);
        push_frame(32'h6002, 32'h6003);
        wait_valid();
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        chk("in_right", 64'(o_is_left), 64'(0));
        chk("in_right_lvl", 64'(o_level), 64'(2));
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 64'(o_valid), 64'(0));
        chk("mid_rst_level", 64'(o_level), 64'(0));
        reset = 1'b0;
        step();
        o_ready = 1'b1;
        push_frame(32'h7000, 32'h7001);
        step();
        chk("post_rst_left", 64'({o_is_left, o_data}), 64'({1'b1, 32'h7000}));
        drain();

        chk("sb_left", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
